led_blink_sched: RTL and testbench

LED_BLINK_SCHED -- requirements
Module: led_blink_sched

---
 rtl/led_pkg.sv | 19 +
 rtl/led_tick_gen.sv | 27 ++
 rtl/led_blink_sched.sv | 120 ++++++++++++
 tb/tb_led_blink_sched.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and sizes for the LED blink scheduler.
package led_pkg;

  localparam int unsigned N_REQ = 3;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StOn,
    StOff,
    StGap
  } state_e;

  function automatic logic [CNT_W-1:0] cnt_field(input logic [N_REQ*CNT_W-1:0] cnts,
                                                 input int unsigned idx);
    return cnts[idx*CNT_W +: CNT_W];
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Half-period tick divider: one-cycle strobe every TICK_DIV cycles while not cleared.
module led_tick_gen #(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = $clog2(TICK_DIV);

  logic [W-1:0] div_q;

  assign tick = !clr && (div_q == W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + W'(1);
    end
  end

endmodule

// File: rtl/led_blink_sched.sv
// Fixed-priority scheduler sharing one LED among requesters, each blinking its latched count
// followed by an off gap.
module led_blink_sched
  import led_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 25_000_000,
  parameter int unsigned GAP_TICKS = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] req_cnt,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic                   led
);

  localparam int unsigned GapW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  state_e             state_q;
  logic [N_REQ-1:0]   grant_q;
  logic [N_REQ-1:0]   done_q;
  logic [CNT_W-1:0]   rem_q;
  logic [GapW-1:0]    gap_q;
  logic               led_q;
  logic               tick;
  logic [N_REQ-1:0]   elig;
  logic [N_REQ-1:0]   pick;
  logic [CNT_W-1:0]   pick_cnt;

  led_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (state_q == StIdle),
    .tick(tick)
  );

  // done_q doubles as the one-cycle mask: it is high exactly in the first IDLE cycle.
  always_comb begin
    elig     = '0;
    pick     = '0;
    pick_cnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = req[i] && (cnt_field(req_cnt, i) != '0) && !done_q[i];
    end
    // Ascending scan so the highest eligible index wins.
    for (int i = 0; i < N_REQ; i++) begin
      if (elig[i]) begin
        pick     = '0;
        pick[i]  = 1'b1;
        pick_cnt = cnt_field(req_cnt, i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      done_q  <= '0;
      rem_q   <= '0;
      gap_q   <= '0;
      led_q   <= 1'b0;
    end else begin
      done_q <= '0;
      unique case (state_q)
        StIdle: begin
          led_q <= 1'b0;
          if (|pick) begin
            grant_q <= pick;
            rem_q   <= pick_cnt;
            led_q   <= 1'b1;
            state_q <= StOn;
          end else begin
            grant_q <= '0;
          end
        end
        StOn: begin
          if (tick) begin
            led_q   <= 1'b0;
            state_q <= StOff;
          end
        end
        StOff: begin
          if (tick) begin
            if (rem_q > CNT_W'(1)) begin
              rem_q   <= rem_q - CNT_W'(1);
              led_q   <= 1'b1;
              state_q <= StOn;
            end else begin
              gap_q   <= '0;
              state_q <= StGap;
            end
          end
        end
        StGap: begin
          if (tick) begin
            if (gap_q == GapW'(GAP_TICKS - 1)) begin
              // grant_q is held through the done cycle so done never pulses without grant.
              done_q  <= grant_q;
              state_q <= StIdle;
            end else begin
              gap_q <= gap_q + GapW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign led   = led_q;
  assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_led_blink_sched.sv
// Bench for led_blink_sched: arbitration table, directed multi-cycle sequences and random
// traffic against a timeline model of each granted sequence.
module tb_led_blink_sched;

  localparam int TD = 4;
  localparam int GT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [11:0] req_cnt;
  logic [2:0]  grant;
  logic [2:0]  done;
  logic        busy;
  logic        led;

  always #5 clk = ~clk;

  led_blink_sched #(
    .TICK_DIV (TD),
    .GAP_TICKS(GT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .req_cnt(req_cnt),
    .grant  (grant),
    .done   (done),
    .busy   (busy),
    .led    (led)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: a granted sequence is a timeline starting at the grant edge.
  int m_owner = -1;
  int m_t0    = 0;
  int m_n     = 0;
  int m_mask  = -1;

  typedef struct {
    logic [2:0]  req;
    logic [11:0] cnt;
    logic [2:0]  exp_grant;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int seq_len(input int n);
    return (2 * n + GT) * TD;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_owner = -1;
      m_mask  = -1;
      return;
    end
    if (m_owner >= 0 && (cyc - m_t0) == seq_len(m_n) + 1) begin
      m_mask  = m_owner;
      m_owner = -1;
    end
    if (m_owner < 0) begin
      for (int i = 2; i >= 0; i--) begin
        if (m_owner < 0 && req[i] && req_cnt[4*i +: 4] != 4'd0 && i != m_mask) begin
          m_owner = i;
          m_t0    = cyc;
          m_n     = int'(req_cnt[4*i +: 4]);
        end
      end
      m_mask = -1;
    end
  endtask

  // Packed {grant, done, busy, led}.
  function automatic logic [7:0] model_out();
    int         d;
    int         len;
    logic [2:0] g;
    if (m_owner < 0) return 8'h00;
    d   = cyc - m_t0;
    len = seq_len(m_n);
    g   = 3'(1 << m_owner);
    return {g, (d == len) ? g : 3'b000, d < len, (d < 2 * m_n * TD) && ((d / TD) % 2 == 0)};
  endfunction

  task automatic step(input string name);
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check(name, {24'd0, grant, done, busy, led}, {24'd0, model_out()});
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    req     = '0;
    req_cnt = '0;
    step("reset");
    step("reset");
    rst = 1'b0;
  endtask

  task automatic wait_done(input string name, input int start, input int budget,
                           output int off, output int led_hi);
    off    = -1;
    led_hi = int'(led);
    for (int k = start + 1; k <= start + budget; k++) begin
      step(name);
      if (led) led_hi++;
      if (done != 3'b000) begin
        off = k;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int off;
    int led_hi;
    int hits;

    tbl[0] = '{3'b001, 12'h003, 3'b001};
    tbl[1] = '{3'b011, 12'h012, 3'b010};
    tbl[2] = '{3'b111, 12'h111, 3'b100};
    tbl[3] = '{3'b100, 12'h0FF, 3'b000};
    tbl[4] = '{3'b110, 12'h050, 3'b010};
    tbl[5] = '{3'b000, 12'hFFF, 3'b000};
    tbl[6] = '{3'b101, 12'hF01, 3'b100};
    tbl[7] = '{3'b111, 12'h007, 3'b001};

    rst     = 1'b1;
    req     = '0;
    req_cnt = '0;
    @(negedge clk);
    do_reset();
    check("reset state", {28'd0, grant, busy}, 32'd0);
    check("reset led/done", {28'd0, done, led}, 32'd0);

    // First-edge arbitration from a fresh IDLE.
    for (int t = 0; t < 8; t++) begin
      do_reset();
      req     = tbl[t].req;
      req_cnt = tbl[t].cnt;
      step("arb table");
      check($sformatf("arb grant[%0d]", t), {29'd0, grant}, {29'd0, tbl[t].exp_grant});
      check($sformatf("arb led/busy[%0d]", t), {30'd0, led, busy},
            {30'd0, |tbl[t].exp_grant, |tbl[t].exp_grant});
    end

    // Single requester, count 3.
    do_reset();
    req     = 3'b001;
    req_cnt = 12'h003;
    step("single grant");
    check("single grant", {29'd0, grant}, 32'd1);
    wait_done("single", 0, 60, off, led_hi);
    check("single done offset", off, 32);
    check("single done bit", {29'd0, done}, 32'd1);
    check("single led-high cycles", led_hi, 12);
    req = '0;
    step("single idle");

    // Two simultaneous requests, back-to-back service.
    do_reset();
    req     = 3'b011;
    req_cnt = 12'h012;
    step("pair grant");
    check("pair first grant", {29'd0, grant}, 32'b010);
    wait_done("pair1", 0, 40, off, led_hi);
    check("pair1 done offset", off, 16);
    check("pair1 done bit", {29'd0, done}, 32'b010);
    req = 3'b001;
    step("pair handoff");
    check("pair second grant", {29'd0, grant}, 32'b001);
    wait_done("pair0", 0, 60, off, led_hi);
    check("pair0 done offset", off, 24);
    check("pair0 done bit", {29'd0, done}, 32'b001);
    req = '0;
    step("pair idle");

    // Held request is masked for one IDLE cycle after its own done.
    do_reset();
    req     = 3'b001;
    req_cnt = 12'h001;
    step("mask grant");
    wait_done("mask", 0, 40, off, led_hi);
    check("mask done offset", off, 16);
    step("mask cycle");
    check("masked cycle grant", {29'd0, grant}, 32'd0);
    step("mask regrant");
    check("regrant after mask", {29'd0, grant}, 32'd1);
    req = '0;

    // Zero-count request is ignored.
    do_reset();
    req     = 3'b100;
    req_cnt = 12'h0AA;
    hits    = 0;
    for (int k = 0; k < 50; k++) begin
      step("zero count");
      if (grant != 3'b000 || led || done != 3'b000) hits++;
    end
    check("zero count activity", hits, 0);

    // Reset during the second ON phase aborts without done.
    do_reset();
    req     = 3'b001;
    req_cnt = 12'h003;
    step("abort grant");
    for (int k = 0; k < 9; k++) step("abort run");
    check("abort pre-reset led", {31'd0, led}, 32'd1);
    rst = 1'b1;
    req = '0;
    step("abort reset");
    check("abort outputs", {24'd0, grant, done, busy, led}, 32'd0);
    rst = 1'b0;
    req = 3'b001;
    step("abort regrant");
    check("abort regrant", {29'd0, grant}, 32'd1);
    wait_done("abort full", 0, 60, off, led_hi);
    check("abort full offset", off, 32);
    req = '0;

    // Request dropped mid-sequence still completes.
    do_reset();
    req     = 3'b001;
    req_cnt = 12'h002;
    step("drop grant");
    for (int k = 0; k < 4; k++) step("drop run");
    req     = 3'b000;
    req_cnt = 12'h00F;
    wait_done("drop", 4, 60, off, led_hi);
    check("drop done offset", off, 24);
    check("drop done bit", {29'd0, done}, 32'd1);

    // Random traffic checked cycle by cycle.
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 7) == 0) req = 3'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        for (int i = 0; i < 3; i++) req_cnt[4*i +: 4] = 4'($urandom_range(0, 3));
      end
      rst = ($urandom_range(0, 299) == 0);
      step("random");
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
